// File: rtl/intra_net_requant.sv
`default_nettype none
// ============================================================================
// Module   : intra_net_requant
// Purpose  : Requantizing transfer engine, output buffer -> activation buffer.
//            Reads len consecutive signed accumulator words, then rounds
//            (half-up), arithmetic-shifts and saturates each word to a signed
//            activation. Write latency is 3 cycles from the read strobe.
// Ports    : clk, reset (async, active-high)
//            start/len/shift     - transfer request, sampled in IDLE
//            O_rd_en/O_rdata     - output-buffer read port (data 1 cycle later)
//            A_wdata/A_wr_en     - activation-buffer write port
//            busy                - first read through last write
//            done                - one-cycle pulse after the last write
//            sat_cnt             - clamped elements in current/last transfer
// Config   : INTRA_NET_RELU_EN - when defined, negative results are forced to
//            0 before saturation and only the upper clamp is counted.
// Revision : 1.0 - initial release
// ============================================================================
module intra_net_requant #(
  parameter int OUT_DATA_WIDTH = 32,
  parameter int ACT_DATA_WIDTH = 8,
  parameter int LEN_WIDTH      = 10,
  parameter int SHIFT_WIDTH    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      len,
  input  logic [SHIFT_WIDTH-1:0]    shift,
  output logic                      O_rd_en,
  input  logic [OUT_DATA_WIDTH-1:0] O_rdata,
  output logic [ACT_DATA_WIDTH-1:0] A_wdata,
  output logic                      A_wr_en,
  output logic                      busy,
  output logic                      done,
  output logic [LEN_WIDTH-1:0]      sat_cnt
);

  // One extra bit keeps x + rounding bias from overflowing at x = max.
  localparam int RW = OUT_DATA_WIDTH + 1;
  localparam logic signed [RW-1:0] c_act_max = RW'((1 << (ACT_DATA_WIDTH-1)) - 1);
  localparam logic signed [RW-1:0] c_act_min = -c_act_max - RW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state, w_next;
  logic [LEN_WIDTH-1:0]     r_remaining;
  logic [SHIFT_WIDTH-1:0]   r_shift;
  logic                     r_v0, r_v1;
  logic signed [RW-1:0]     r_s1;

  logic                     w_accept;
  logic signed [RW-1:0]     w_x, w_bias, w_round, w_pos;
  logic                     w_hi, w_lo, w_clamp;
  logic [ACT_DATA_WIDTH-1:0] w_act;

  assign w_accept = (r_state == S_IDLE) && start;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    O_rd_en = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        O_rd_en = 1'b1;
        if (r_remaining == LEN_WIDTH'(1)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // S2 output register drains in the same cycle v1 clears.
        if (!r_v0 && !r_v1) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_RUN) || (r_state == S_DRAIN) || r_v0 || r_v1 || A_wr_en;

  // ---------------- transfer control ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remaining <= '0;
      r_shift     <= '0;
    end else if (w_accept && (len != '0)) begin
      r_remaining <= len;
      r_shift     <= shift;
    end else if (r_state == S_RUN) begin
      r_remaining <= r_remaining - LEN_WIDTH'(1);
    end
  end

  // ---------------- S1: round and shift ----------------
  assign w_x     = RW'($signed(O_rdata));
  assign w_bias  = (r_shift == '0) ? '0 : (RW'(1) << (r_shift - SHIFT_WIDTH'(1)));
  assign w_round = (w_x + w_bias) >>> r_shift;

  // ---------------- S2: saturate ----------------
`ifdef INTRA_NET_RELU_EN
  assign w_pos   = (r_s1 < 0) ? '0 : r_s1;
`else
  assign w_pos   = r_s1;
`endif
  assign w_hi    = w_pos > c_act_max;
  assign w_lo    = w_pos < c_act_min;
  assign w_clamp = w_hi || w_lo;
  assign w_act   = w_hi ? {1'b0, {(ACT_DATA_WIDTH-1){1'b1}}} :
                   w_lo ? {1'b1, {(ACT_DATA_WIDTH-1){1'b0}}} :
                          w_pos[ACT_DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_s1    <= '0;
      A_wr_en <= 1'b0;
      A_wdata <= '0;
      sat_cnt <= '0;
    end else begin
      r_v0    <= O_rd_en;
      r_v1    <= r_v0;
      r_s1    <= w_round;
      A_wr_en <= r_v1;
      if (r_v1) A_wdata <= w_act;
      if (w_accept)             sat_cnt <= '0;
      else if (r_v1 && w_clamp) sat_cnt <= sat_cnt + LEN_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/intra_net_requant.md
# intra_net_requant

Requantizing transfer engine for the intra-network path from output buffer to activation buffer. It reads len consecutive 32-bit accumulator results, then rounds, shifts and saturates each one to an 8-bit activation. Each result is emitted with a write strobe to the activation buffer. Its busy output drives the start_signal of the intra-net address generator, so buffer addresses and data stay cycle-aligned.

## Interface
- OUT_DATA_WIDTH, 32, output-buffer word width (signed accumulator)
- ACT_DATA_WIDTH, 8, activation word width (signed)
- LEN_WIDTH, 10, width of the transfer length
- SHIFT_WIDTH, 5, width of the right-shift amount
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle request; accepted only in IDLE
- len  in  LEN_WIDTH  number of words to transfer; sampled with start
- shift  in  SHIFT_WIDTH  arithmetic right-shift amount; sampled with start
- O_rd_en  out  1  output-buffer read strobe, one word per cycle
- O_rdata  in  OUT_DATA_WIDTH  output-buffer read data, valid exactly 1 cycle after O_rd_en
- A_wdata  out  ACT_DATA_WIDTH  requantized activation
- A_wr_en  out  1  activation-buffer write strobe qualifying A_wdata
- busy  out  1  high from first read through last write; drives the address generator's start_signal
- done  out  1  one-cycle pulse after the last write
- sat_cnt  out  LEN_WIDTH  number of saturated elements in the current or last transfer

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with len != 0 latches len and shift, clears sat_cnt, and moves to RUN.
  - start with len == 0 goes straight to DONE, with no reads and no writes.
- RUN:
  - O_rd_en = 1 every cycle; the remaining counter decrements.
  - When the last read is issued, the FSM moves to DRAIN.
- DRAIN: O_rd_en = 0; wait until the valid pipeline is empty, then move to DONE.
- DONE: done = 1 for one cycle, then return to IDLE.
- start while not in IDLE is ignored; it does not affect the running transfer.
- Pipeline (valid bits shifted alongside the data):
  - S0: O_rdata arrives, qualified by the delayed O_rd_en.
  - S1: round and shift into a 33-bit signed intermediate, r = (x + (shift ? 2^(shift-1) : 0)) >>> shift. Rounding is half-up toward +inf. shift = 0 passes x through unchanged.
  - S2: saturate r to [-128, 127], register it to A_wdata, and assert A_wr_en.
- sat_cnt increments in S2 whenever clamping occurs. It holds its value after done and clears on the next accepted start.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - O_rd_en, A_wr_en, busy, done are 0.
  - A_wdata = 0; sat_cnt = 0.
- Request to first read: start accepted at edge t puts the FSM in RUN from cycle t+1, so O_rd_en is high for cycles t+1 … t+len.
- Read to write latency: 3 cycles. A read at cycle k produces A_wr_en at cycle k+3. Writes are contiguous, len cycles, with no bubbles.
- busy:
  - Goes high in the same cycle as the first O_rd_en.
  - Stays high through the cycle of the last A_wr_en (cycle t+len+3).
  - Is combinational from state plus pipeline valids.
- done: asserts at cycle t+len+4 and lasts one cycle. For len = 0, done asserts at t+1 and busy never rises.
- Counter boundary: len = 2^LEN_WIDTH-1 must complete correctly, with no wrap of the remaining counter.
- Reset mid-transfer:
  - All outputs return to their reset values immediately.
  - In-flight pipeline data is discarded; no further A_wr_en.
- Intermediate width: 33 bits prevents overflow when rounding x = 0x7FFFFFFF.

## Configuration
- INTRA_NET_RELU_EN defined: after rounding, r < 0 is forced to 0 before saturation, so the output range is [0, 127]. ReLU clamping is not counted in sat_cnt; only the >127 clamp counts.
- INTRA_NET_RELU_EN undefined: signed saturation to [-128, 127], and both clamps count in sat_cnt.

## Test plan
- Basic pass-through: start with len = 4, shift = 0, O_rdata 5, -3, 100, 127 -> A_wdata 5, -3, 100, 127 on 4 consecutive A_wr_en cycles. First write is 3 cycles after the first O_rd_en; done occurs one cycle after the last write.
- Rounding: shift = 4, O_rdata 24, 23, -24, -25 -> A_wdata 2, 1, -1, -2.
- Saturation: shift = 0, O_rdata 300, -300, 0x7FFFFFFF, 0x80000000 -> A_wdata 127, -128, 127, -128 and sat_cnt = 4.
  - With INTRA_NET_RELU_EN: the same stimulus gives A_wdata 127, 0, 127, 0 and sat_cnt = 2.
- Edge lengths and start handling:
  - len = 0 -> done pulse one cycle after start; no O_rd_en, no A_wr_en, busy stays 0.
  - start asserted while busy -> ignored; the original len is honoured.
- Reset mid-transfer: with len = 8, assert reset after 3 writes -> A_wr_en and busy drop in the same cycle, no done pulse, sat_cnt = 0. A new start afterwards runs cleanly.
- Back-to-back: start again in the cycle after done -> the second transfer begins with O_rd_en one cycle later, and sat_cnt is cleared.
